stream_rr_arbiter: RTL

N:1 packet arbiter for the streaming crossbar output side. It shares one valid/ready/last output stream between S_DATA_COUNT requesters using round-robin.
- Once a requester is granted, the grant stays locked until that requester's last beat is accepted.
- Packets are never interleaved.
- The block presents the winning source index on m_id_o, so downstream knows which input a beat came from.

---
 rtl/stream_rr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: N:1 round-robin packet arbiter for a valid/ready/last stream.
// A grant is taken in IDLE (one bubble cycle) and held until the granted
// requester's last beat is accepted, so packets are never interleaved.
module stream_rr_arbiter #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic                                 busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [T_ID___WIDTH-1:0] r_grant;
    logic [T_ID___WIDTH-1:0] w_grantNext;
    logic [T_ID___WIDTH-1:0] r_lastGrant;
    logic [T_ID___WIDTH-1:0] w_lastGrantNext;
    logic [T_ID___WIDTH-1:0] w_winner;
    logic                    w_found;
    logic                    w_xfer;
    logic [T_DATA_WIDTH-1:0] w_lane [S_DATA_COUNT];

    // Split the packed requester data bus into one lane per requester.
    always_comb begin
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            w_lane[k] = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
        end
    end

    // Cyclic search for the first valid requester after the round-robin pointer;
    // the wrap is an explicit modulo so non-power-of-2 counts (e.g. 3) wrap 2->0.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= S_DATA_COUNT; k++) begin
            int cand;
            cand = (int'(r_lastGrant) + k) % S_DATA_COUNT;
            if (!w_found && s_valid_i[T_ID___WIDTH'(cand)]) begin
                w_found  = 1'b1;
                w_winner = T_ID___WIDTH'(cand);
            end
        end
    end

    assign w_xfer = (r_state == BUSY) && s_valid_i[r_grant] && m_ready_i;

    // Next-state logic: grab a winner in IDLE, release only on an accepted last beat.
    always_comb begin
        w_stateNext     = r_state;
        w_grantNext     = r_grant;
        w_lastGrantNext = r_lastGrant;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_stateNext = BUSY;
                    w_grantNext = w_winner;
                end
            end
            BUSY: begin
                if (w_xfer && s_last_i[r_grant]) begin
                    w_stateNext     = IDLE;
                    w_lastGrantNext = r_grant;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Output mux: everything is zero in IDLE; in BUSY the granted requester drives the stream.
    always_comb begin
        s_ready_o = '0;
        m_data_o  = '0;
        m_id_o    = '0;
        m_last_o  = 1'b0;
        m_valid_o = 1'b0;
        busy_o    = 1'b0;
        if (r_state == BUSY) begin
            m_data_o           = w_lane[r_grant];
            m_id_o             = r_grant;
            m_last_o           = s_last_i[r_grant];
            m_valid_o          = s_valid_i[r_grant];
            busy_o             = 1'b1;
            s_ready_o[r_grant] = m_ready_i;
        end
    end

    // State register; the pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_lastGrant <= T_ID___WIDTH'(S_DATA_COUNT - 1);
        end else begin
            r_state     <= w_stateNext;
            r_grant     <= w_grantNext;
            r_lastGrant <= w_lastGrantNext;
        end
    end

endmodule
